// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter: FSM state codes,
// grant-id encoding and default bus/watchdog sizes.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned TO_CYCLES_DEF = 255;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t IF_BUSY = 2'd1;
    localparam state_t DM_BUSY = 2'd2;

    typedef logic gnt_t;

    localparam gnt_t GNT_IF = 1'b0;
    localparam gnt_t GNT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Unified memory bus between the arbiter (master) and the memory (slave).
// Signal names match the legacy flat port names of mem_arbiter.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and raises
// timeout once TO_CYCLES cycles have elapsed; the count holds at the limit.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int unsigned CNT_W = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TO_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !timeout) begin
            count <= count + CNT_W'(1);
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one memory bus.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests (default: DM priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              if_stall_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              dm_stall_o,

    mem_arb_if.master         mem,

    output logic              err_o
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              timeout;
    logic              grant_any;
    gnt_t              grant_id;

    assign grant_any = start_i & (if_req_i | dm_req_i);

`ifdef MEM_ARB_RR_EN
    gnt_t last_gnt;

    // On a tie the requester that did not win last time gets the bus.
    always_comb begin
        grant_id = GNT_IF;
        if (if_req_i && dm_req_i) begin
            grant_id = (last_gnt == GNT_IF) ? GNT_DM : GNT_IF;
        end else if (dm_req_i) begin
            grant_id = GNT_DM;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt <= GNT_IF;
        end else if (state == IDLE && grant_any) begin
            last_gnt <= grant_id;
        end
    end
`else
    always_comb begin
        grant_id = dm_req_i ? GNT_DM : GNT_IF;
    end
`endif

    mem_arb_watchdog #(
        .TO_CYCLES (TO_CYCLES)
    ) u_watchdog (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (state == IDLE),
        .enable  (state != IDLE),
        .timeout (timeout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_o <= '0;
            if_valid_o <= 1'b0;
            dm_rdata_o <= '0;
            dm_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            if_valid_o <= 1'b0;
            dm_valid_o <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        if (grant_id == GNT_DM) begin
                            state   <= DM_BUSY;
                            addr_q  <= dm_addr_i;
                            we_q    <= dm_we_i;
                            wdata_q <= dm_wdata_i;
                        end else begin
                            state   <= IF_BUSY;
                            addr_q  <= if_addr_i;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end
                    end
                end
                IF_BUSY: begin
                    // Ack is tested first so a same-cycle timeout loses.
                    if (mem.mem_ack_i) begin
                        if_rdata_o <= mem.mem_rdata_i;
                        if_valid_o <= 1'b1;
                        state      <= IDLE;
                    end else if (timeout) begin
                        if_rdata_o <= '0;
                        if_valid_o <= 1'b1;
                        err_o      <= 1'b1;
                        state      <= IDLE;
                    end
                end
                DM_BUSY: begin
                    if (mem.mem_ack_i) begin
                        if (!we_q) begin
                            dm_rdata_o <= mem.mem_rdata_i;
                        end
                        dm_valid_o <= 1'b1;
                        state      <= IDLE;
                    end else if (timeout) begin
                        dm_rdata_o <= '0;
                        dm_valid_o <= 1'b1;
                        err_o      <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req_o   = (state != IDLE);
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;

    assign if_stall_o = if_req_i & ~if_valid_o;
    assign dm_stall_o = dm_req_i & ~dm_valid_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i, start_i;
    logic          if_req_i, dm_req_i, dm_we_i;
    logic [AW-1:0] if_addr_i, dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic [DW-1:0] if_rdata_o, dm_rdata_o;
    logic          if_valid_o, if_stall_o, dm_valid_o, dm_stall_o, err_o;

    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TO_CYCLES(TO)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_valid_o (if_valid_o),
        .if_stall_o (if_stall_o),
        .dm_req_i   (dm_req_i),
        .dm_we_i    (dm_we_i),
        .dm_addr_i  (dm_addr_i),
        .dm_wdata_i (dm_wdata_i),
        .dm_rdata_o (dm_rdata_o),
        .dm_valid_o (dm_valid_o),
        .dm_stall_o (dm_stall_o),
        .mem        (mem_bus),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks, n_fail;

    // Model: owner 0 = none, 1 = fetch, 2 = data; waited = busy cycles already elapsed.
    int            m_owner, m_last, m_waited, m_lat;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] e_if_rdata, e_dm_rdata;
    logic          e_if_valid, e_dm_valid, e_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 1; m_waited = 0; m_lat = 0;
        m_addr = '0; m_we = 1'b0; m_wdata = '0;
        e_if_rdata = '0; e_dm_rdata = '0;
        e_if_valid = 1'b0; e_dm_valid = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_step();
        int pick;
        e_if_valid = 1'b0; e_dm_valid = 1'b0; e_err = 1'b0;
        if (m_owner == 0) begin
            if (start_i && (if_req_i || dm_req_i)) begin
                if (if_req_i && dm_req_i) pick = RR ? ((m_last == 1) ? 2 : 1) : 2;
                else                      pick = dm_req_i ? 2 : 1;
                m_owner = pick; m_last = pick; m_waited = 0;
                m_lat = $urandom_range(0, 10);
                m_addr  = (pick == 2) ? dm_addr_i : if_addr_i;
                m_we    = (pick == 2) ? dm_we_i : 1'b0;
                m_wdata = dm_wdata_i;
            end
        end else if (mem_bus.mem_ack_i) begin
            if (m_owner == 1) begin
                e_if_valid = 1'b1; e_if_rdata = mem_bus.mem_rdata_i;
            end else begin
                e_dm_valid = 1'b1;
                if (!m_we) e_dm_rdata = mem_bus.mem_rdata_i;
            end
            m_owner = 0;
        end else if (m_waited == int'(TO)) begin
            e_err = 1'b1;
            if (m_owner == 1) begin e_if_valid = 1'b1; e_if_rdata = '0; end
            else              begin e_dm_valid = 1'b1; e_dm_rdata = '0; end
            m_owner = 0;
        end else begin
            m_waited++;
        end
    endtask

    task automatic compare();
        chk("mem_req", mem_bus.mem_req_o, m_owner != 0);
        if (m_owner != 0) begin
            chk("mem_addr", mem_bus.mem_addr_o, m_addr);
            chk("mem_we", mem_bus.mem_we_o, m_we);
            if (m_we) chk("mem_wdata", mem_bus.mem_wdata_o, m_wdata);
        end
        chk("if_valid", if_valid_o, e_if_valid);
        chk("if_rdata", if_rdata_o, e_if_rdata);
        chk("dm_valid", dm_valid_o, e_dm_valid);
        chk("dm_rdata", dm_rdata_o, e_dm_rdata);
        chk("err", err_o, e_err);
        chk("if_stall", if_stall_o, if_req_i & ~e_if_valid);
        chk("dm_stall", dm_stall_o, dm_req_i & ~e_dm_valid);
    endtask

    // Called at a falling edge with this cycle's inputs applied.
    task automatic cycle();
        #1;
        compare();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int            stall_n, valid_n, valid_at, busy_n, err_at, k;
        logic          prev_req;
        logic [AW-1:0] got_g[3];
        logic [AW-1:0] exp_g[3];

        n_checks = 0; n_fail = 0;
        rst_i = 1'b1; start_i = 1'b0;
        if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = '0;
        model_reset();
        @(negedge clk); @(negedge clk);

        chk("reset_mem_req", mem_bus.mem_req_o, 0);
        chk("reset_mem_addr", mem_bus.mem_addr_o, 0);
        chk("reset_if_valid", if_valid_o, 0);
        chk("reset_dm_valid", dm_valid_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_if_rdata", if_rdata_o, 0);
        chk("reset_dm_rdata", dm_rdata_o, 0);
        rst_i = 1'b0;
        cycle();

        // Fetch only: ack on the 4th busy cycle, 5 stall cycles, valid 5 cycles after request.
        if_addr_i = 32'h40; if_req_i = 1'b1;
        stall_n = 0; valid_n = 0; valid_at = -1;
        for (int i = 0; i < 6; i++) begin
            start_i = (i == 0);
            mem_bus.mem_ack_i = (m_owner != 0) && (m_waited == 3);
            mem_bus.mem_rdata_i = mem_bus.mem_ack_i ? 32'h8C020004 : $urandom;
            #1;
            if (if_stall_o) stall_n++;
            if (if_valid_o) begin
                valid_n++; valid_at = i;
                chk("fetch_rdata", if_rdata_o, 32'h8C020004);
            end
            if (i == 1) begin
                chk("fetch_addr", mem_bus.mem_addr_o, 32'h40);
                chk("fetch_we", mem_bus.mem_we_o, 0);
            end
            cycle();
        end
        chk("fetch_stall_cycles", stall_n, 5);
        chk("fetch_valid_pulses", valid_n, 1);
        chk("fetch_latency", valid_at, 5);
        if_req_i = 1'b0; mem_bus.mem_ack_i = 1'b0;
        cycle();

        // Simultaneous requests: DM write first, fetch after dm_valid.
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h10; dm_wdata_i = 32'hAB;
        if_req_i = 1'b1; if_addr_i = 32'h40; start_i = 1'b1;
        cycle();
        chk("simul_first_addr", mem_bus.mem_addr_o, 32'h10);
        chk("simul_first_we", mem_bus.mem_we_o, 1);
        chk("simul_first_wdata", mem_bus.mem_wdata_o, 32'hAB);
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = $urandom;
        cycle();
        dm_req_i = 1'b0; mem_bus.mem_ack_i = 1'b0;
        #1;
        chk("simul_dm_valid", dm_valid_o, 1);
        chk("simul_write_keeps_rdata", dm_rdata_o, 0);
        cycle();
        chk("simul_then_if_addr", mem_bus.mem_addr_o, 32'h40);
        chk("simul_then_if_we", mem_bus.mem_we_o, 0);
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = $urandom;
        cycle();
        if_req_i = 1'b0; start_i = 1'b0; mem_bus.mem_ack_i = 1'b0;
        cycle();

        // Three back-to-back simultaneous pairs; DM reads with immediate ack.
        if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h10;
        if_addr_i = 32'h40; start_i = 1'b1; k = 0; prev_req = 1'b0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            mem_bus.mem_ack_i = (m_owner != 0);
            mem_bus.mem_rdata_i = 32'h5500_0000 | i;
            #1;
            if (mem_bus.mem_req_o && !prev_req) begin
                got_g[k] = mem_bus.mem_addr_o; k++;
            end
            prev_req = mem_bus.mem_req_o;
            cycle();
        end
        if_req_i = 1'b0; dm_req_i = 1'b0; start_i = 1'b0; mem_bus.mem_ack_i = 1'b0;
        cycle(); cycle();
`ifdef MEM_ARB_RR_EN
        exp_g[0] = 32'h10; exp_g[1] = 32'h40; exp_g[2] = 32'h10;
`else
        exp_g[0] = 32'h10; exp_g[1] = 32'h10; exp_g[2] = 32'h10;
`endif
        chk("pair_grants_seen", k, 3);
        for (int j = 0; j < 3; j++) chk("pair_grant_order", got_g[j], exp_g[j]);

        // Watchdog: no ack, err on the cycle after the 9th busy cycle.
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20; start_i = 1'b1;
        busy_n = 0; err_at = -1;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (err_o && err_at < 0) begin
                err_at = busy_n;
                chk("timeout_dm_valid", dm_valid_o, 1);
                chk("timeout_dm_rdata", dm_rdata_o, 0);
                chk("timeout_idle", mem_bus.mem_req_o, 0);
            end
            if (mem_bus.mem_req_o) busy_n++;
            cycle();
            start_i = 1'b0;
        end
        chk("timeout_busy_cycles", err_at, 9);
        dm_req_i = 1'b0;
        cycle();

        // Reset mid DM_BUSY, then a late ack.
        dm_req_i = 1'b1; dm_addr_i = 32'h30; start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        cycle();
        #2;
        rst_i = 1'b1;
        #1;
        chk("midreset_mem_req", mem_bus.mem_req_o, 0);
        chk("midreset_dm_valid", dm_valid_o, 0);
        @(posedge clk); @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        dm_req_i = 1'b0; mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = $urandom;
        valid_n = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (dm_valid_o) valid_n++;
            cycle();
            mem_bus.mem_ack_i = 1'b0;
        end
        chk("late_ack_no_valid", valid_n, 0);

        // start_i low blocks grants.
        if_req_i = 1'b1; dm_req_i = 1'b1; start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("nostart_mem_req", mem_bus.mem_req_o, 0);
            chk("nostart_if_stall", if_stall_o, 1);
            chk("nostart_dm_stall", dm_stall_o, 1);
            cycle();
        end
        if_req_i = 1'b0; dm_req_i = 1'b0;
        cycle();

        // Randomized traffic, including drops mid-access and stray acks.
        for (int i = 0; i < 600; i++) begin
            start_i    = ($urandom_range(0, 7) != 0);
            if_req_i   = $urandom_range(0, 1);
            dm_req_i   = $urandom_range(0, 1);
            dm_we_i    = $urandom_range(0, 1);
            if_addr_i  = $urandom;
            dm_addr_i  = $urandom;
            dm_wdata_i = $urandom;
            mem_bus.mem_rdata_i = $urandom;
            if (m_owner != 0) mem_bus.mem_ack_i = (m_waited == m_lat);
            else              mem_bus.mem_ack_i = ($urandom_range(0, 3) == 0);
            cycle();
        end

        start_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            mem_bus.mem_ack_i = (m_owner != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TO_CYCLES, default 255, watchdog limit in cycles.
REQ-004 SHALL have ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  enables new grants.
- if_req_i  in  1  fetch request.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetch data.
- if_valid_o  out  1  fetch done, one-cycle pulse.
- if_stall_o  out  1  stall to PC and IF/ID.
- dm_req_i  in  1  data request.
- dm_we_i  in  1  data write enable.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  data write value.
- dm_rdata_o  out  DATA_W  data read value.
- dm_valid_o  out  1  data done, one-cycle pulse.
- dm_stall_o  out  1  stall to the whole pipeline.
- mem_req_o  out  1  unified memory request.
- mem_we_o  out  1  unified memory write.
- mem_addr_o  out  ADDR_W  unified memory address.
- mem_wdata_o  out  DATA_W  unified memory write data.
- mem_rdata_i  in  DATA_W  unified memory read data.
- mem_ack_i  in  1  unified memory completion, one cycle.
- err_o  out  1  watchdog abort, one-cycle pulse.

Function
REQ-005 SHALL implement FSM states IDLE, IF_BUSY, DM_BUSY.
REQ-006 In IDLE with start_i=1, SHALL grant dm_req_i before if_req_i, register addr/we/wdata and move to the BUSY state of the granted requester.
REQ-007 SHALL make no grant while start_i=0; an access already in a BUSY state SHALL complete.
REQ-008 SHALL drive mem_req_o=1 in both BUSY states and 0 in IDLE; mem_addr_o/mem_we_o/mem_wdata_o SHALL stay stable from the grant until ack.
REQ-009 A fetch access SHALL drive mem_we_o=0.
REQ-010 On mem_ack_i in a BUSY state, SHALL register mem_rdata_i into the owner's rdata output, pulse the owner's valid on the next cycle and return to IDLE.
REQ-011 Minimum latency, request to valid: 2 cycles plus memory latency.
REQ-012 On a write ack, SHALL leave dm_rdata_o unchanged and still pulse dm_valid_o.
REQ-013 SHALL compute if_stall_o = if_req_i & ~if_valid_o and dm_stall_o = dm_req_i & ~dm_valid_o combinationally.
REQ-014 If a requester drops its request mid-access, SHALL complete the memory access and still pulse valid.
REQ-015 SHALL ignore mem_ack_i in IDLE.
REQ-016 SHALL count cycles in a BUSY state. At TO_CYCLES without ack it SHALL:
- go to IDLE;
- pulse err_o;
- pulse the owner's valid with rdata 0.
REQ-017 If ack and timeout occur in the same cycle, ack SHALL win and err_o SHALL stay 0.

Reset
REQ-018 On rst_i, asynchronously and regardless of state:
- state SHALL be IDLE;
- the watchdog counter SHALL be 0;
- all registered outputs and the last-grant register SHALL be 0;
- an in-flight access SHALL be abandoned without a valid pulse.

Configuration
REQ-019 The macro MEM_ARB_RR_EN SHALL select round-robin arbitration.
- Defined: on simultaneous requests, grant SHALL go to the requester not granted last; the last-grant register resets to the IF encoding, so DM is granted first.
- Undefined: fixed DM priority per REQ-006 and no last-grant register.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the FSM state typedef, the grant-id encoding (GNT_IF, GNT_DM) and the default width constants.
REQ-021 The watchdog SHALL be a separate sub-module, mem_arb_watchdog, with clear/enable inputs and a timeout output.

Verification
REQ-022 Verification SHALL cover these directed scenarios:
- Fetch only: if_addr_i=0x40, ack after 3 cycles with 0x8C020004 -> if_rdata_o=0x8C020004, if_valid_o pulse, if_stall_o high for 5 cycles.
- Simultaneous requests, no macro: DM write addr 0x10 data 0xAB -> mem_we_o=1, addr 0x10 first; fetch granted after dm_valid_o.
- With MEM_ARB_RR_EN: three back-to-back simultaneous request pairs -> grants DM, IF, DM.
- No ack for TO_CYCLES=8 -> err_o pulse on the 9th busy cycle, valid pulse, rdata 0, FSM back in IDLE.
- rst_i raised mid DM_BUSY, then a late ack -> no valid pulse, mem_req_o=0 immediately.
- start_i=0 with both requests pending -> mem_req_o stays 0, both stalls stay 1.
